blink_detector: RTL

//  Receive-side counterpart of the LED blinker. Samples an asynchronous

---
 rtl/blink_detector.sv | 139 +++++++++++++
 1 files changed

// File: rtl/blink_detector.sv
// Blink-source checker: synchronizes an asynchronous square wave, measures the
// edge-to-edge interval in clk cycles and locks when it matches the expected half-period.
module blink_detector #(
  parameter int  CLK_FREQ_KHz = 50000,
  parameter int  LED_FREQ_Hz  = 1,
  parameter int  TOL_CYCLES   = 1000,
  parameter int  LOCK_COUNT   = 3,
  localparam int HALF_PERIOD  = (CLK_FREQ_KHz * 1000) / (LED_FREQ_Hz * 2),
  localparam int MAX_CNT      = 2 * HALF_PERIOD,
  localparam int CNT_W        = $clog2(MAX_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blink_in,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W:0]   HP_X     = (CNT_W + 1)'(HALF_PERIOD);
  localparam logic [CNT_W:0]   TOL_X    = (CNT_W + 1)'(TOL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CNT - 1);
  localparam logic [MC_W-1:0]  MC_LOCK  = MC_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             edge_p0;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   interval_p0;
  logic             is_match_p0;
  logic [MC_W-1:0]  match_cnt;
  logic [MC_W-1:0]  mc_nxt;
  logic             upd_p0;
  logic             to_p0;

  // Distance from the nominal half-period; one extra bit so the sum never wraps.
  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W:0] a,
                                              input logic [CNT_W:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Synchronizer and edge stage
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= blink_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_p0     = s2 ^ s3;
  assign interval_p0 = (CNT_W + 1)'(cnt) + (CNT_W + 1)'(1);
  assign is_match_p0 = (abs_diff(interval_p0, HP_X) <= TOL_X);

  // Measurement FSM: next state and update strobes
  always_comb begin
    state_nxt = state;
    mc_nxt    = match_cnt;
    upd_p0    = 1'b0;
    to_p0     = 1'b0;
    case (state)
      IDLE: begin
        if (edge_p0) state_nxt = MEASURE;
      end
      MEASURE, LOCKED: begin
        if (edge_p0) begin
          upd_p0 = 1'b1;
          if (!is_match_p0) begin
            state_nxt = MEASURE;
            mc_nxt    = '0;
          end else if (state == MEASURE) begin
            if (match_cnt >= MC_LOCK - MC_W'(1)) begin
              state_nxt = LOCKED;
              mc_nxt    = MC_LOCK;
            end else begin
              mc_nxt = match_cnt + MC_W'(1);
            end
          end
        end else if (cnt == CNT_LAST) begin
          // An edge landing on this same cycle is handled above, so it wins.
          state_nxt = IDLE;
          mc_nxt    = '0;
          to_p0     = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        mc_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      match_cnt <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= mc_nxt;
      cnt       <= (edge_p0 || state_nxt == IDLE) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_pulse   <= 1'b0;
      half_period  <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      edge_pulse   <= edge_p0;
      period_valid <= upd_p0;
      locked       <= (state_nxt == LOCKED);
      timeout      <= to_p0;
      if (upd_p0) half_period <= interval_p0[CNT_W-1:0];
    end
  end

endmodule
